// File: rtl/led_pkg.sv
// led_pkg: panel size defaults, frame loader state encoding and the gamma-2.2 table.
package led_pkg;
   localparam int COLS_DEF  = 64;
   localparam int ROWS_DEF  = 32;
   localparam int PIX_W_DEF = 12;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP, SWAP} ld_state_e;
   // entry x holds round(15 * (x/15)^2.2); index 15 is the leftmost nibble
   localparam logic [15:0][3:0] GAMMA_LUT = {
      4'd15, 4'd13, 4'd11, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4,
      4'd3,  4'd2,  4'd1,  4'd1, 4'd0, 4'd0, 4'd0, 4'd0
   };
endpackage

// File: rtl/frame_loader_if.sv
// frame_loader_if: upstream pixel stream plus frame-buffer write port.
interface frame_loader_if #(
   parameter int PIX_W = led_pkg::PIX_W_DEF,
   parameter int AW    = 12
);
   logic             px_valid, px_sof, px_ready, wr_en;
   logic [PIX_W-1:0] px_data, wr_data;
   logic [AW-1:0]    wr_addr;
   modport master (output px_valid, px_sof, px_data, input px_ready, wr_en, wr_addr, wr_data);
   modport slave  (input px_valid, px_sof, px_data, output px_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/gamma_lut4.sv
// gamma_lut4: registered 4-bit gamma-2.2 lookup for one colour channel.
module gamma_lut4 import led_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);
   logic [3:0] q_q;
   always_ff @(posedge clk) q_q <= rst ? 4'd0 : GAMMA_LUT[d_i];
   assign q_o = q_q;
endmodule

// File: rtl/frame_loader.sv
// frame_loader: double-buffered frame loader that swaps banks on frame_done.
// Define FRAME_LOADER_GAMMA_EN to add a gamma-2.2 stage (writes become 2 cycles late).
module frame_loader import led_pkg::*; #(
   parameter int COLS  = COLS_DEF,
   parameter int ROWS  = ROWS_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   frame_loader_if.slave px,
   input  logic          frame_done,
   output logic          rd_bank,
   output logic          init,
   output logic          err_sync
);
   localparam int N      = COLS * ROWS;
   localparam int ADDR_W = $clog2(N);
   ld_state_e         state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              rd_bank_q, init_q, err_q, wr_en_q;
   logic [ADDR_W:0]   wr_addr_q;
   logic [PIX_W-1:0]  wr_data_q;
   logic              acc, sof, wr, last;
   assign px.px_ready = state_q == IDLE || state_q == LOAD;
   assign acc  = px.px_valid && px.px_ready;
   assign sof  = acc && px.px_sof;
   assign wr   = sof || (acc && state_q == LOAD);
   assign last = wr && !sof && cnt_q == ADDR_W'(N - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_bank_q <= 1'b0;
         init_q    <= 1'b0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= wr;
         if (wr) begin
            wr_addr_q <= {~rd_bank_q, sof ? ADDR_W'(0) : cnt_q};
            wr_data_q <= px.px_data;
         end
         case (state_q)
            IDLE: if (sof) begin
               state_q <= LOAD;
               cnt_q   <= ADDR_W'(1);
            end
            LOAD: if (sof) begin
               err_q <= 1'b1;
               cnt_q <= ADDR_W'(1);
            end else if (last) state_q <= WAIT_SWAP;
            else if (acc) cnt_q <= cnt_q + 1'b1;
            // bank and init flip on entry so they are already new during SWAP
            WAIT_SWAP: if (!init_q || frame_done) begin
               state_q   <= SWAP;
               rd_bank_q <= ~rd_bank_q;
               init_q    <= 1'b1;
            end
            SWAP: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end
`ifdef FRAME_LOADER_GAMMA_EN
   logic            wr_en2_q;
   logic [ADDR_W:0] wr_addr2_q;
   always_ff @(posedge clk) begin
      wr_en2_q   <= !rst && wr_en_q;
      wr_addr2_q <= rst ? '0 : wr_addr_q;
   end
   for (genvar c = 0; c < 3; c++) begin : g_ch
      gamma_lut4 u_lut (.clk(clk), .rst(rst), .d_i(wr_data_q[4*c +: 4]), .q_o(px.wr_data[4*c +: 4]));
   end
   assign px.wr_en   = wr_en2_q;
   assign px.wr_addr = wr_addr2_q;
`else
   assign px.wr_en   = wr_en_q;
   assign px.wr_addr = wr_addr_q;
   assign px.wr_data = wr_data_q;
`endif
   assign rd_bank  = rd_bank_q;
   assign init     = init_q;
   assign err_sync = err_q;
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: random-gap pixel streams checked every cycle against a frame-level model.
module tb_frame_loader;
   localparam int N = 2048;
`ifdef FRAME_LOADER_GAMMA_EN
   localparam int LAT = 2;
   localparam logic [11:0] F80_OUT = 12'hF40;
`else
   localparam int LAT = 1;
   localparam logic [11:0] F80_OUT = 12'hF80;
`endif
   logic clk = 1'b0, rst = 1'b1, frame_done = 1'b0;
   logic rd_bank, init, err_sync;
   frame_loader_if #(.PIX_W(12), .AW(12)) bus ();
   frame_loader dut (
      .clk(clk), .rst(rst), .px(bus), .frame_done(frame_done),
      .rd_bank(rd_bank), .init(init), .err_sync(err_sync)
   );
   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, n_wr = 0, base;
   bit rnd_fd = 0;
   logic [11:0] last_wa = '0;
   logic [3:0] gtab [16];
   initial for (int i = 0; i < 16; i++) gtab[i] = 4'($rtoi(15.0 * ((i / 15.0) ** 2.2) + 0.5));

   function automatic logic [11:0] xform(input logic [11:0] d);
`ifdef FRAME_LOADER_GAMMA_EN
      return {gtab[d[11:8]], gtab[d[7:4]], gtab[d[3:0]]};
`else
      return d;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position, bank ownership and swap timing.
   bit m_rd = 0, m_init = 0, m_err = 0, m_ready = 1, m_reopen = 0, m_pending = 0;
   int m_pos = -1;
   bit p_en [LAT] = '{default: 0};
   logic [11:0] p_addr [LAT] = '{default: '0};
   logic [11:0] p_data [LAT] = '{default: '0};
   always @(posedge clk) begin
      bit we, pend_old;
      logic [11:0] wa;
      we = 0;
      wa = '0;
      pend_old = m_pending;
      if (rst) begin
         m_rd = 0; m_init = 0; m_err = 0; m_ready = 1; m_reopen = 0; m_pending = 0; m_pos = -1;
      end else begin
         if (bus.px_valid && m_ready) begin
            if (bus.px_sof) begin
               m_err = m_err | (m_pos >= 0);
               m_pos = 0;
            end
            if (m_pos >= 0) begin
               we = 1;
               wa = {~m_rd, 11'(m_pos)};
               m_pos++;
               if (m_pos == N) begin
                  m_pos = -1; m_ready = 0; m_pending = 1;
               end
            end
         end
         if (m_reopen) begin
            m_ready = 1; m_reopen = 0;
         end
         if (pend_old && (!m_init || frame_done)) begin
            m_rd = ~m_rd; m_init = 1; m_pending = 0; m_reopen = 1;
         end
      end
      for (int i = LAT - 1; i > 0; i--) begin
         p_en[i] = p_en[i-1]; p_addr[i] = p_addr[i-1]; p_data[i] = p_data[i-1];
      end
      p_en[0] = we; p_addr[0] = wa; p_data[0] = xform(bus.px_data);
      if (rst) for (int i = 0; i < LAT; i++) p_en[i] = 0;
   end

   always @(negedge clk) begin
      check("wr_en", 32'(bus.wr_en), 32'(p_en[LAT-1]));
      if (p_en[LAT-1]) begin
         check("wr_addr", 32'(bus.wr_addr), 32'(p_addr[LAT-1]));
         check("wr_data", 32'(bus.wr_data), 32'(p_data[LAT-1]));
      end
      check("px_ready", 32'(bus.px_ready), 32'(m_ready));
      check("rd_bank", 32'(rd_bank), 32'(m_rd));
      check("init", 32'(init), 32'(m_init));
      check("err_sync", 32'(err_sync), 32'(m_err));
      if (bus.wr_en) begin
         n_wr++;
         last_wa = bus.wr_addr;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sof, input logic [11:0] d);
      bit done = 0;
      for (int t = 0; t < 2000 && !done; t++) begin
         frame_done = rnd_fd && ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.px_valid = 1'b0;
            cyc();
         end else begin
            bus.px_valid = 1'b1; bus.px_sof = sof; bus.px_data = d;
            done = bus.px_ready;
            cyc();
         end
      end
      bus.px_valid = 1'b0; bus.px_sof = 1'b0; frame_done = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL send: pixel not accepted within 2000 cycles at %0t", $time);
      end
   endtask

   task automatic frame_body(input int n, input int sof_odds);
      for (int i = 0; i < n; i++) send(sof_odds > 0 && $urandom_range(1, sof_odds) == 1, 12'($urandom));
   endtask

   initial begin
      bus.px_valid = 1'b0; bus.px_sof = 1'b0; bus.px_data = '0;
      repeat (3) cyc();
      rst = 1'b0;
      check("reset wr_en", 32'(bus.wr_en), 0);
      check("reset wr_addr", 32'(bus.wr_addr), 0);
      check("reset wr_data", 32'(bus.wr_data), 0);
      check("reset rd_bank", 32'(rd_bank), 0);
      check("reset init", 32'(init), 0);
      check("reset err_sync", 32'(err_sync), 0);
      check("reset px_ready", 32'(bus.px_ready), 1);
      base = n_wr;
      frame_body(10, 0);
      repeat (3) cyc();
      check("idle discard writes", n_wr - base, 0);
      base = n_wr;
      send(1, 12'($urandom));
      frame_body(N - 1, 0);
      check("f1 rd_bank before swap", 32'(rd_bank), 0);
      cyc();
      check("f1 rd_bank", 32'(rd_bank), 1);
      check("f1 init", 32'(init), 1);
      check("f1 ready in swap", 32'(bus.px_ready), 0);
      repeat (2) cyc();
      check("f1 write count", n_wr - base, N);
      check("f1 last addr", 32'(last_wa), 32'hFFF);
      send(1, 12'($urandom));
      frame_body(N - 1, 0);
      repeat (20) cyc();
      check("f2 ready withheld", 32'(bus.px_ready), 0);
      check("f2 rd_bank withheld", 32'(rd_bank), 1);
      check("f2 last addr", 32'(last_wa), 32'h7FF);
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
      check("f2 rd_bank after done", 32'(rd_bank), 0);
      cyc();
      check("f2 ready after swap", 32'(bus.px_ready), 1);
      send(1, 12'($urandom));
      frame_body(99, 0);
      send(1, 12'($urandom));
      check("f3 err_sync", 32'(err_sync), 1);
      repeat (LAT - 1) cyc();
      check("f3 restart wr_en", 32'(bus.wr_en), 1);
      check("f3 restart addr", 32'(bus.wr_addr), 32'h800);
      frame_body(N - 1, 0);
      check("f3 rd_bank before done", 32'(rd_bank), 0);
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
      check("f3 coincident swap", 32'(rd_bank), 1);
      check("f3 err sticky", 32'(err_sync), 1);
      cyc();
      send(1, 12'($urandom));
      frame_body(499, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("abort wr_en", 32'(bus.wr_en), 0);
      check("abort init", 32'(init), 0);
      check("abort rd_bank", 32'(rd_bank), 0);
      check("abort err_sync", 32'(err_sync), 0);
      repeat (5) cyc();
      check("abort no swap", 32'(rd_bank), 0);
      bus.px_valid = 1'b1; bus.px_sof = 1'b1; bus.px_data = 12'hF80;
      cyc();
      bus.px_valid = 1'b0; bus.px_sof = 1'b0;
      repeat (LAT - 1) cyc();
      check("F80 wr_en", 32'(bus.wr_en), 1);
      check("F80 wr_data", 32'(bus.wr_data), 32'(F80_OUT));
      check("F80 wr_addr", 32'(bus.wr_addr), 32'h800);
      rnd_fd = 1;
      frame_body(N - 1, 1500);
      for (int f = 0; f < 2; f++) begin
         send(1, 12'($urandom));
         frame_body(N - 1, 1500);
      end
      for (int i = 0; i < 60; i++) begin
         frame_done = $urandom_range(0, 7) == 0;
         cyc();
      end
      frame_done = 1'b0;
      rnd_fd = 0;
      repeat (3) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
